// File: rtl/plane_setup_pkg.sv
// Shared rasterizer definitions: default coefficient/coordinate widths, derived
// cross-product widths and the plane-setup state encoding.
package plane_setup_pkg;

    localparam int ZW   = 18;
    localparam int CW   = 16;
    localparam int FRAC = 11;

    function automatic int area_w(input int cw);
        return 2 * (cw + 1) + 1;
    endfunction

    function automatic int norm_w(input int zw, input int cw);
        return (zw + 1) + (cw + 1) + 1;
    endfunction

    localparam int AW = area_w(CW);
    localparam int NW = norm_w(ZW, CW);
    localparam int QB = NW;

    typedef enum logic [2:0] {
        IDLE,
        CROSS,
        DIV,
        COEF,
        DONE
    } state_t;

endpackage

// File: rtl/plane_setup_div.sv
// Serial restoring sign-magnitude divider, one quotient bit per clock.
// The first bit is resolved on the start edge, so NUM_W-1 further edges complete it.
module serial_div #(
    parameter int NUM_W = plane_setup_pkg::NW,
    parameter int DEN_W = plane_setup_pkg::AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [NUM_W-1:0] dividend,
    input  logic signed [DEN_W-1:0] divisor,
    output logic                    busy,
    output logic signed [NUM_W:0]   quotient
);
    localparam int CNT_W = $clog2(NUM_W);

    logic [DEN_W-1:0] rem, rem_in, rem_nx, d, d_in, mag_d;
    logic [NUM_W-1:0] q, q_in, q_nx, mag_n;
    logic [DEN_W:0]   sh, diff;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    assign mag_n = dividend[NUM_W-1] ? NUM_W'(-dividend) : NUM_W'(dividend);
    assign mag_d = divisor[DEN_W-1] ? DEN_W'(-divisor) : DEN_W'(divisor);

    // q shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        rem_in = start ? '0 : rem;
        q_in   = start ? mag_n : q;
        d_in   = start ? mag_d : d;
        sh     = {rem_in, q_in[NUM_W-1]};
        diff   = sh - {1'b0, d_in};
        rem_nx = diff[DEN_W] ? sh[DEN_W-1:0] : diff[DEN_W-1:0];
        q_nx   = {q_in[NUM_W-2:0], ~diff[DEN_W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            q   <= '0;
            d   <= '0;
            neg <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            rem <= rem_nx;
            q   <= q_nx;
            d   <= mag_d;
            neg <= dividend[NUM_W-1] ^ divisor[DEN_W-1];
            cnt <= CNT_W'(NUM_W - 1);
        end else if (busy) begin
            rem <= rem_nx;
            q   <= q_nx;
            cnt <= cnt - 1'b1;
        end
    end

    assign busy     = (cnt != '0);
    assign quotient = neg ? -$signed({1'b0, q}) : $signed({1'b0, q});

endmodule

// File: rtl/plane_setup.sv
// Triangle depth-plane setup: latches a vertex triple and produces z = c + dzdx*x + dzdy*y.
// Edge cross products feed two serial dividers; c is derived once the slopes are known.
module plane_setup #(
    parameter int ZW   = plane_setup_pkg::ZW,
    parameter int CW   = plane_setup_pkg::CW,
    parameter int FRAC = plane_setup_pkg::FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        vx [3],
    input  logic [CW-1:0]        vy [3],
    input  logic signed [ZW-1:0] vz [3],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [ZW-1:0] dzdx,
    output logic signed [ZW-1:0] dzdy,
    output logic signed [ZW-1:0] c,
    output logic                 degenerate
);
    import plane_setup_pkg::*;

    localparam int A_BITS = area_w(CW);
    localparam int N_BITS = norm_w(ZW, CW);
    localparam int WW     = N_BITS + 2;
    localparam int IW     = ZW - FRAC;
    // largest Q(IW).FRAC value
    localparam logic signed [WW-1:0] ZMAX = WW'(((longint'(1) << (IW - 1)) << FRAC) - 1);
    localparam logic signed [WW-1:0] ZMIN = ~ZMAX;

    state_t state, state_nx;

    logic [CW-1:0]              x_r [3];
    logic [CW-1:0]              y_r [3];
    logic signed [ZW-1:0]       z_r [3];
    logic signed [CW:0]         ex1, ey1, ex2, ey2;
    logic signed [ZW:0]         ez1, ez2;
    logic signed [A_BITS-1:0]   a_prod;
    logic signed [N_BITS-1:0]   nx_prod, ny_prod;
    logic                       a_zero, div_start, busy_x, busy_y;
    logic signed [N_BITS:0]     quot_x, quot_y;
    logic signed [ZW-1:0]       qx_sat, qy_sat;
    logic signed [WW-1:0]       c_full;

    function automatic logic signed [ZW-1:0] sat(input logic signed [WW-1:0] v);
        if (v > ZMAX) return ZW'(ZMAX);
        if (v < ZMIN) return ZW'(ZMIN);
        return ZW'(v);
    endfunction

    always_comb begin
        ex1     = $signed({1'b0, x_r[1]}) - $signed({1'b0, x_r[0]});
        ey1     = $signed({1'b0, y_r[1]}) - $signed({1'b0, y_r[0]});
        ex2     = $signed({1'b0, x_r[2]}) - $signed({1'b0, x_r[0]});
        ey2     = $signed({1'b0, y_r[2]}) - $signed({1'b0, y_r[0]});
        ez1     = (ZW+1)'(z_r[1]) - (ZW+1)'(z_r[0]);
        ez2     = (ZW+1)'(z_r[2]) - (ZW+1)'(z_r[0]);
        a_prod  = A_BITS'(ex1) * A_BITS'(ey2) - A_BITS'(ex2) * A_BITS'(ey1);
        nx_prod = N_BITS'(ez1) * N_BITS'(ey2) - N_BITS'(ez2) * N_BITS'(ey1);
        ny_prod = N_BITS'(ex1) * N_BITS'(ez2) - N_BITS'(ex2) * N_BITS'(ez1);
        a_zero  = (a_prod == '0);
    end

    serial_div #(.NUM_W(N_BITS), .DEN_W(A_BITS)) u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (nx_prod),
        .divisor  (a_prod),
        .busy     (busy_x),
        .quotient (quot_x)
    );

    serial_div #(.NUM_W(N_BITS), .DEN_W(A_BITS)) u_div_y (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (ny_prod),
        .divisor  (a_prod),
        .busy     (busy_y),
        .quotient (quot_y)
    );

    // slopes are the saturated ones that get registered, so c matches what the evaluator sees
    always_comb begin
        qx_sat = degenerate ? '0 : sat(WW'(quot_x));
        qy_sat = degenerate ? '0 : sat(WW'(quot_y));
        c_full = WW'(z_r[0])
               - WW'(qx_sat) * WW'($signed({1'b0, x_r[0]}))
               - WW'(qy_sat) * WW'($signed({1'b0, y_r[0]}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CROSS;
            CROSS:   state_nx = a_zero ? COEF : DIV;
            DIV:     if (!(busy_x || busy_y)) state_nx = COEF;
            COEF:    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        div_start = (state == CROSS) && !a_zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r        <= '{default: '0};
            y_r        <= '{default: '0};
            z_r        <= '{default: '0};
            degenerate <= 1'b0;
            dzdx       <= '0;
            dzdy       <= '0;
            c          <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                x_r <= vx;
                y_r <= vy;
                z_r <= vz;
            end
            if (state == CROSS) degenerate <= a_zero;
            if (state == COEF) begin
                dzdx <= qx_sat;
                dzdy <= qy_sat;
                c    <= sat(c_full);
            end
        end
    end

endmodule
